// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg
//   Shared definitions for the M-extension multiply/divide execute unit:
//   func3 encodings, FSM state types, default operand width and small
//   func3 decode helpers.
package ex_muldiv_unit_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        DV_IDLE,
        DV_MAG,
        DV_ITER,
        DV_FIX
    } div_phase_t;

    // {rs1 signed, rs2 signed} for the multiply group.
    function automatic logic [1:0] mul_signs(input logic [2:0] f3);
        logic [1:0] s;
        s = 2'b00;
        case (f3)
            F3_MULH:          s = 2'b11;
            F3_MULHSU:        s = 2'b10;
            F3_MUL, F3_MULHU: s = 2'b00;
            default:          s = 2'b00;
        endcase
        return s;
    endfunction

    function automatic logic div_signed(input logic [2:0] f3);
        logic s;
        s = 1'b0;
        case (f3)
            F3_DIV, F3_REM:   s = 1'b1;
            F3_DIVU, F3_REMU: s = 1'b0;
            default:          s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
//   Issue/result handshake bundle between the ID/EX stage and the
//   multiply/divide unit.
//   in_valid/in_ready  : op handshake (in_func3, in_rs1, in_rs2, in_rd)
//   out_valid/out_ready: result handshake (out_result, out_rd)
//   master = issuing pipeline side, slave = the execute unit.
interface ex_muldiv_unit_if
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_func3;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [RD_W-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [RD_W-1:0] out_rd;

    modport master (
        output in_valid, in_func3, in_rs1, in_rs2, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd
    );

    modport slave (
        input  in_valid, in_func3, in_rs1, in_rs2, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd
    );
endinterface

// File: rtl/ex_muldiv_unit_divider.sv
// muldiv_divider
//   Iterative restoring divider, one quotient bit per cycle.
//   Cycle after start: operand magnitudes; then XLEN iterations; then a
//   fixup cycle where done=1 and quot/rem carry the signed results.
//   Ports: clk, rst_n (async, active-low), kill (abandon op), start
//   (latch dividend/divisor/is_signed), done, quot, rem.
//   Divide by zero yields quot = all ones, rem = dividend; the signed
//   overflow case falls out of the magnitude arithmetic naturally.
module muldiv_divider
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);
    localparam int unsigned CW = $clog2(XLEN);

    div_phase_t      phase;
    logic [XLEN-1:0] acc_q;   // dividend magnitude; quotient bits shift in from the bottom
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic [CW-1:0]   cnt;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            qbit;

    // rem_q < divisor always holds, so the trial difference fits in XLEN+1
    // bits and its MSB is a clean borrow flag.
    always_comb begin
        shifted = {rem_q, acc_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        qbit    = ~diff[XLEN];
    end

    always_comb begin
        done = (phase == DV_FIX);
        if (b_zero) begin
            quot = '1;
        end else if (a_neg ^ b_neg) begin
            quot = -acc_q;
        end else begin
            quot = acc_q;
        end
        rem = a_neg ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= DV_IDLE;
            acc_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
            cnt    <= '0;
        end else if (kill) begin
            phase <= DV_IDLE;
        end else if (start) begin
            acc_q  <= dividend;
            dvs_q  <= divisor;
            a_neg  <= is_signed & dividend[XLEN-1];
            b_neg  <= is_signed & divisor[XLEN-1];
            b_zero <= (divisor == '0);
            phase  <= DV_MAG;
        end else begin
            case (phase)
                DV_MAG: begin
                    acc_q <= a_neg ? -acc_q : acc_q;
                    dvs_q <= b_neg ? -dvs_q : dvs_q;
                    rem_q <= '0;
                    cnt   <= '0;
                    phase <= DV_ITER;
                end
                DV_ITER: begin
                    rem_q <= qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                    acc_q <= {acc_q[XLEN-2:0], qbit};
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(XLEN - 1)) begin
                        phase <= DV_FIX;
                    end
                end
                DV_FIX:  phase <= DV_IDLE;
                default: phase <= DV_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Multi-cycle RISC-V M-extension execute unit (MUL/MULH/MULHSU/MULHU,
//   DIV/DIVU/REM/REMU) beside the single-cycle ALU.
//   Ports: clk, rst_n (async, active-low), flush (kill in-flight op),
//   busy (not IDLE), bus (slave side of ex_muldiv_unit_if).
//   Multiply: result valid MUL_STAGES cycles after accept.
//   Divide:   result valid XLEN+2 cycles after accept.
//   Result and rd are held with out_valid until out_ready.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEFAULT,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned RD_W       = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    output logic           busy,
    ex_muldiv_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(MUL_STAGES + 1);

    state_t            state;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [RD_W-1:0]   rd_q;
    logic [CW-1:0]     mul_cnt;
    logic              accept;

    logic [1:0]        sg;
    logic [2*XLEN-1:0] a_x;
    logic [2*XLEN-1:0] b_x;
    logic [2*XLEN-1:0] prod_c;
    logic [2*XLEN-1:0] prod_out;

    logic              div_done;
    logic [XLEN-1:0]   div_quot;
    logic [XLEN-1:0]   div_rem;

    assign bus.in_ready = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign accept       = bus.in_valid && bus.in_ready && !flush;

    // Extending both operands to 2*XLEN makes the modular product equal the
    // exact signed/unsigned product for every multiply flavour.
    always_comb begin
        sg     = mul_signs(f3_q);
        a_x    = {{XLEN{sg[1] & op_a[XLEN-1]}}, op_a};
        b_x    = {{XLEN{sg[0] & op_b[XLEN-1]}}, op_b};
        prod_c = a_x * b_x;
    end

    // Register stages behind the multiplier array; the result capture into
    // out_result is the last stage, so MUL_STAGES-1 registers sit here.
    generate
        if (MUL_STAGES == 1) begin : g_mul_comb
            assign prod_out = prod_c;
        end else begin : g_mul_pipe
            logic [2*XLEN-1:0] pipe [MUL_STAGES-1];
            always_ff @(posedge clk) begin
                pipe[0] <= prod_c;
                for (int unsigned i = 1; i < MUL_STAGES - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
            assign prod_out = pipe[MUL_STAGES-2];
        end
    endgenerate

    muldiv_divider #(
        .XLEN(XLEN)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .kill      (flush),
        .start     (accept && bus.in_func3[2]),
        .is_signed (div_signed(bus.in_func3)),
        .dividend  (bus.in_rs1),
        .divisor   (bus.in_rs2),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            f3_q           <= '0;
            op_a           <= '0;
            op_b           <= '0;
            rd_q           <= '0;
            mul_cnt        <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_rd     <= '0;
        end else if (flush) begin
            state         <= ST_IDLE;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        f3_q    <= bus.in_func3;
                        op_a    <= bus.in_rs1;
                        op_b    <= bus.in_rs2;
                        rd_q    <= bus.in_rd;
                        mul_cnt <= '0;
                        state   <= bus.in_func3[2] ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mul_cnt == CW'(MUL_STAGES - 1)) begin
                        bus.out_result <= (f3_q == F3_MUL) ? prod_out[XLEN-1:0]
                                                           : prod_out[2*XLEN-1:XLEN];
                        bus.out_rd     <= rd_q;
                        bus.out_valid  <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        mul_cnt <= mul_cnt + CW'(1);
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        bus.out_result <= is_rem(f3_q) ? div_rem : div_quot;
                        bus.out_rd     <= rd_q;
                        bus.out_valid  <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit
//   Directed-vector bench for ex_muldiv_unit. A per-cycle compare process
//   tracks in-flight ops with a queue and arithmetic reference results;
//   directed ops additionally check hand-computed literals and latency.
module tb_ex_muldiv_unit;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_STAGES = 2;
    localparam int unsigned RD_W       = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    ex_muldiv_unit_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

    ex_muldiv_unit #(
        .XLEN       (XLEN),
        .MUL_STAGES (MUL_STAGES),
        .RD_W       (RD_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the ISA definitions.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r  = '0;
        case (f)
            3'b000: begin p = sa * sb; r = p[31:0];  end
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * ub; r = p[63:32]; end
            3'b011: begin p = ua * ub; r = p[63:32]; end
            3'b100: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'(sa / sb);
            end
            3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = 32'(sa % sb);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [2:0] f);
        return f[2] ? int'(XLEN + 2) : int'(MUL_STAGES);
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t q[$];

    // Per-cycle compare: inputs change just after posedge, so at negedge they
    // describe what the next posedge will see.
    always @(negedge clk) begin : cmp
        logic busy_m;
        logic ov_m;
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_out_result", 64'(bus.out_result), 64'd0);
            chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
        end else begin
            busy_m = (q.size() != 0);
            ov_m   = 1'b0;
            if (busy_m) ov_m = (cyc >= q[0].due);
            chk("in_ready", 64'(bus.in_ready), 64'(!busy_m));
            chk("busy", 64'(busy), 64'(busy_m));
            chk("out_valid", 64'(bus.out_valid), 64'(ov_m));
            if (ov_m && bus.out_valid) begin
                chk("out_result", 64'(bus.out_result), 64'(q[0].res));
                chk("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
            end
            if (flush) begin
                q.delete();
            end else if (!busy_m && bus.in_valid) begin
                q.push_back('{model(bus.in_func3, bus.in_rs1, bus.in_rs2), bus.in_rd,
                              cyc + 1 + latency(bus.in_func3)});
            end else if (ov_m && bus.out_ready) begin
                void'(q.pop_front());
            end
        end
    end

    // Present an op for one accept edge, then scramble the inputs.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.in_func3 = f;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_rd    = rd;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_func3 = 3'($urandom);
        bus.in_rs1   = $urandom;
        bus.in_rs2   = $urandom;
        bus.in_rd    = 5'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] lit, input int lat_lit,
                         input int hold);
        int lat;
        chk("model_pin", 64'(model(f, a, b)), 64'(lit));
        issue(f, a, b, rd);
        wait_valid(lat);
        chk("latency", 64'(lat), 64'(lat_lit));
        chk("lit_result", 64'(bus.out_result), 64'(lit));
        chk("lit_rd", 64'(bus.out_rd), 64'(rd));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            chk("hold_result", 64'(bus.out_result), 64'(lit));
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("idle_after_done", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int lat;
        rst_n        = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_func3 = '0;
        bus.in_rs1   = '0;
        bus.in_rs2   = '0;
        bus.in_rd    = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // multiply group
        do_op(3'b000, 32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 2, 0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 2, 0);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000, 2, 1);
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 2, 0);
        do_op(3'b000, 32'h0001_0000, 32'h0001_0000, 5'd5,  32'h0000_0000, 2, 0);
        do_op(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd6,  32'h0000_0001, 2, 0);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 2, 0);
        do_op(3'b010, 32'd2,         32'h8000_0000, 5'd8,  32'h0000_0001, 2, 0);
        do_op(3'b010, 32'hFFFF_FFFE, 32'h8000_0000, 5'd9,  32'hFFFF_FFFF, 2, 0);

        // divide group
        do_op(3'b100, 32'hFFFF_FFEC, 32'd3,         5'd10, 32'hFFFF_FFFA, 34, 0);
        do_op(3'b110, 32'hFFFF_FFEC, 32'd3,         5'd11, 32'hFFFF_FFFE, 34, 10);
        do_op(3'b101, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 34, 0);
        do_op(3'b111, 32'd5,         32'd0,         5'd13, 32'h0000_0005, 34, 0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 34, 0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 34, 0);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd0,         5'd16, 32'hFFFF_FFFF, 34, 0);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFF9, 34, 0);
        do_op(3'b101, 32'd100,       32'd7,         5'd18, 32'h0000_000E, 34, 0);
        do_op(3'b111, 32'd100,       32'd7,         5'd19, 32'h0000_0002, 34, 0);
        do_op(3'b100, 32'd20,        32'hFFFF_FFFD, 5'd20, 32'hFFFF_FFFA, 34, 0);
        do_op(3'b110, 32'd20,        32'hFFFF_FFFD, 5'd21, 32'h0000_0002, 34, 0);

        // flush at the 10th divide iteration (accept edge + 11)
        issue(3'b100, 32'd1000, 32'd7, 5'd22);
        repeat (10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_div_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_div_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_div_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            chk("flush_div_no_result", 64'(bus.out_valid), 64'd0);
        end

        // flush together with a valid op in IDLE: op must be dropped
        bus.in_valid = 1'b1;
        bus.in_func3 = 3'b000;
        bus.in_rs1   = 32'd3;
        bus.in_rs2   = 32'd4;
        flush        = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        chk("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_idle_busy", 64'(busy), 64'd0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("flush_idle_no_result", 64'(bus.out_valid), 64'd0);

        // flush wins over out_ready in DONE
        issue(3'b000, 32'd6, 32'd7, 5'd23);
        wait_valid(lat);
        chk("flush_done_latency", 64'(lat), 64'd2);
        chk("flush_done_result", 64'(bus.out_result), 64'd42);
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        chk("flush_done_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_done_in_ready", 64'(bus.in_ready), 64'd1);

        // async reset one cycle into a multiply
        issue(3'b000, 32'd9, 32'd9, 5'd24);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_mid_out_rd", 64'(bus.out_rd), 64'd0);
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_no_result", 64'(bus.out_valid), 64'd0);

        do_op(3'b000, 32'd12, 32'd11, 5'd25, 32'd132, 2, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
